mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/arbiter_types.sv | 24 ++
 rtl/arb_req_reg.sv | 25 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_types.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant
// identity and the captured request bundle.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } arb_req_t;

endpackage

// File: rtl/arb_req_reg.sv
// Capture register for the granted request bundle (address, rd/wr, wmask,
// wdata); loads only when a grant is issued.
module arb_req_reg
  import arbiter_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     load_i,
  input  arb_req_t req_i,
  output arb_req_t req_o
);

  arb_req_t req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else if (load_i) begin
      req_q <= req_i;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (imem/dmem) to single-port memory arbiter. The granted request
// is captured and replayed to memory until mem_resp; response is same-cycle.
module mem_arbiter
  import arbiter_types::*;
#(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_address,
  input  logic        imem_read,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_address,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  arb_state_t state_q;
  arb_grant_t last_grant_q;
  arb_grant_t grant;
  logic       grant_v;
  logic       i_req;
  logic       d_req;
  arb_req_t   req_d;
  arb_req_t   req_q;

  always_comb begin
    i_req   = imem_read;
    d_req   = dmem_read | dmem_write;
    grant_v = (state_q == IDLE) && (i_req || d_req);
    grant   = GRANT_I;
    if (i_req && d_req) begin
      if (FAIR != 0) begin
        grant = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
      end else begin
        grant = GRANT_D;
      end
    end else if (d_req) begin
      grant = GRANT_D;
    end

    req_d = '0;
    if (grant == GRANT_D) begin
      // Simultaneous read+write from dmem is issued as a write only.
      req_d.addr  = dmem_address;
      req_d.wr    = dmem_write;
      req_d.rd    = dmem_read & ~dmem_write;
      req_d.wmask = dmem_wmask;
      req_d.wdata = dmem_wdata;
    end else begin
      req_d.addr = imem_address;
      req_d.rd   = 1'b1;
    end
  end

  arb_req_reg u_req_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (grant_v),
    .req_i  (req_d),
    .req_o  (req_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_v) begin
            state_q      <= (grant == GRANT_D) ? SERVE_D : SERVE_I;
            last_grant_q <= grant;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory side replays only the captured request; strobes vanish outside service.
  assign mem_address = req_q.addr;
  assign mem_wmask   = req_q.wmask;
  assign mem_wdata   = req_q.wdata;
  assign mem_read    = (state_q != IDLE) & req_q.rd;
  assign mem_write   = (state_q != IDLE) & req_q.wr;

  assign imem_resp   = (state_q == SERVE_I) & mem_resp;
  assign dmem_resp   = (state_q == SERVE_D) & mem_resp;
  assign imem_rdata  = imem_resp ? mem_rdata : '0;
  assign dmem_rdata  = dmem_resp ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_mem_arbiter;

  localparam logic [31:0] IA = 32'h0000_0060;
  localparam logic [31:0] DA = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_address, dmem_address, dmem_wdata, mem_rdata;
  logic        imem_read, dmem_read, dmem_write, mem_resp;
  logic [3:0]  dmem_wmask;
  logic [31:0] imem_rdata, dmem_rdata, mem_address, mem_wdata;
  logic        imem_resp, dmem_resp, mem_read, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] imem_rdata0, dmem_rdata0, mem_address0, mem_wdata0;
  logic        imem_resp0, dmem_resp0, mem_read0, mem_write0;
  logic [3:0]  mem_wmask0;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR(1)) u_dut (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  mem_arbiter #(.FAIR(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata0), .imem_resp(imem_resp0),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata0), .dmem_resp(dmem_resp0),
    .mem_address(mem_address0), .mem_read(mem_read0), .mem_write(mem_write0),
    .mem_wmask(mem_wmask0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic        rst, ird, drd, dwr, mresp;
    logic [31:0] mrdata;
    logic        erd, ewr;
    logic [31:0] eaddr;
    logic [1:0]  eresp;   // {imem_resp, dmem_resp} of FAIR=1
    logic [1:0]  eresp0;  // same for FAIR=0
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int r, input int ir, input int dr, input int dw,
                              input int mr, input logic [31:0] rd_data,
                              input int erd, input int ewr, input logic [31:0] eaddr,
                              input int eresp, input int eresp0);
    vec_t v;
    v.rst = (r != 0); v.ird = (ir != 0); v.drd = (dr != 0); v.dwr = (dw != 0);
    v.mresp = (mr != 0); v.mrdata = rd_data;
    v.erd = (erd != 0); v.ewr = (ewr != 0); v.eaddr = eaddr;
    v.eresp = 2'(eresp); v.eresp0 = 2'(eresp0);
    return v;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    imem_read = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0; mem_resp = 1'b0;
    mem_rdata = '0;
  endtask

  // Transaction-level reference state for the random run.
  logic        m_busy, m_who, m_last, m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wmask;
  logic        any_d;

  initial begin
    vec_t tbl[$];
    rst = 1'b1;
    imem_address = IA; dmem_address = DA; dmem_wmask = 4'h0; dmem_wdata = '0;
    idle_in();

    // Single imem read, 3-cycle memory, then a stray mem_resp while idle.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,             1, 0, IA, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,             1, 0, IA, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,             1, 0, IA, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h13,        1, 0, IA, 2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,             1, 0, IA, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h17,        1, 0, IA, 2, 2));
    // Held tie after reset: FAIR=1 alternates D,I,D; FAIR=0 always D.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,             1, 0, DA, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h1111_0001, 1, 0, DA, 1, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,             1, 0, IA, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h2222_0002, 1, 0, IA, 2, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,             0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0,             1, 0, DA, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h3333_0003, 1, 0, DA, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,             0, 0, 0,  0, 0));

    #1;
    foreach (tbl[k]) begin
      rst = tbl[k].rst; imem_read = tbl[k].ird; dmem_read = tbl[k].drd;
      dmem_write = tbl[k].dwr; mem_resp = tbl[k].mresp; mem_rdata = tbl[k].mrdata;
      @(negedge clk);
      chk($sformatf("vec%0d mem_read", k), 32'(mem_read), 32'(tbl[k].erd));
      chk($sformatf("vec%0d mem_write", k), 32'(mem_write), 32'(tbl[k].ewr));
      chk($sformatf("vec%0d resp", k), 32'({imem_resp, dmem_resp}), 32'(tbl[k].eresp));
      chk($sformatf("vec%0d imem_rdata", k), imem_rdata, tbl[k].eresp[1] ? tbl[k].mrdata : 32'h0);
      chk($sformatf("vec%0d dmem_rdata", k), dmem_rdata, tbl[k].eresp[0] ? tbl[k].mrdata : 32'h0);
      chk($sformatf("vec%0d resp_fair0", k), 32'({imem_resp0, dmem_resp0}), 32'(tbl[k].eresp0));
      if (tbl[k].erd || tbl[k].ewr)
        chk($sformatf("vec%0d mem_address", k), mem_address, tbl[k].eaddr);
      if (tbl[k].rst) begin
        chk($sformatf("vec%0d rst mem_address", k), mem_address, 32'h0);
        chk($sformatf("vec%0d rst mem_wdata", k), mem_wdata, 32'h0);
        chk($sformatf("vec%0d rst mem_wmask", k), 32'(mem_wmask), 32'h0);
      end
      next_cycle();
    end

    // Captured write survives input changes; read+write is issued as write.
    idle_in();
    dmem_read = 1'b1; dmem_write = 1'b1; dmem_address = 32'h1004;
    dmem_wmask = 4'b0110; dmem_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    chk("cap N mem_write", 32'(mem_write), 32'h0);
    next_cycle();
    dmem_write = 1'b0; dmem_address = 32'h5555_0000; dmem_wmask = 4'b1001;
    dmem_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("cap mem_write", 32'(mem_write), 32'h1);
    chk("cap mem_read", 32'(mem_read), 32'h0);
    chk("cap mem_address", mem_address, 32'h1004);
    chk("cap mem_wmask", 32'(mem_wmask), 32'h6);
    chk("cap mem_wdata", mem_wdata, 32'hAABB_CCDD);
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("cap dmem_resp", 32'(dmem_resp), 32'h1);
    chk("cap imem_resp", 32'(imem_resp), 32'h0);
    chk("cap mem_address late", mem_address, 32'h1004);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("cap idle mem_write", 32'(mem_write), 32'h0);
    next_cycle();

    // imem drops its request mid-service; transaction still completes once.
    imem_read = 1'b1; imem_address = 32'h80;
    @(negedge clk);
    chk("drop N mem_read", 32'(mem_read), 32'h0);
    next_cycle();
    imem_read = 1'b0;
    @(negedge clk);
    chk("drop mem_read", 32'(mem_read), 32'h1);
    chk("drop mem_address", mem_address, 32'h80);
    next_cycle();
    mem_resp = 1'b1; mem_rdata = 32'h93;
    @(negedge clk);
    chk("drop imem_resp", 32'(imem_resp), 32'h1);
    chk("drop imem_rdata", imem_rdata, 32'h93);
    next_cycle();
    mem_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("drop after%0d imem_resp", c), 32'(imem_resp), 32'h0);
      chk($sformatf("drop after%0d mem_read", c), 32'(mem_read), 32'h0);
      next_cycle();
    end

    // Reset during a dmem write, then a tie must go to D again.
    dmem_write = 1'b1; dmem_address = 32'h300; dmem_wmask = 4'hF; dmem_wdata = 32'h5A5A_5A5A;
    next_cycle();
    @(negedge clk);
    chk("rstmid mem_write before", 32'(mem_write), 32'h1);
    mem_resp = 1'b1; rst = 1'b1;
    #1;
    chk("rstmid mem_write", 32'(mem_write), 32'h0);
    chk("rstmid dmem_resp", 32'(dmem_resp), 32'h0);
    chk("rstmid mem_address", mem_address, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; mem_resp = 1'b0; imem_read = 1'b1; imem_address = IA;
    @(negedge clk);
    chk("rstmid tie N mem_write", 32'(mem_write), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rstmid tie mem_write", 32'(mem_write), 32'h1);
    chk("rstmid tie mem_read", 32'(mem_read), 32'h0);
    chk("rstmid tie mem_address", mem_address, 32'h300);
    next_cycle();
    idle_in();

    // Randomized run against the transaction model.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m_busy = 1'b0; m_last = 1'b0; m_who = 1'b0;
    for (int c = 0; c < 400; c++) begin
      imem_read    = ($urandom_range(0, 1) == 0);
      dmem_read    = ($urandom_range(0, 3) == 0);
      dmem_write   = ($urandom_range(0, 2) == 0);
      imem_address = $urandom; dmem_address = $urandom;
      dmem_wmask   = 4'($urandom); dmem_wdata = $urandom;
      mem_resp     = ($urandom_range(0, 2) == 0);
      mem_rdata    = $urandom;
      @(negedge clk);
      chk($sformatf("rnd%0d mem_read", c), 32'(mem_read), 32'(m_busy && m_rd));
      chk($sformatf("rnd%0d mem_write", c), 32'(mem_write), 32'(m_busy && m_wr));
      chk($sformatf("rnd%0d imem_resp", c), 32'(imem_resp), 32'(m_busy && !m_who && mem_resp));
      chk($sformatf("rnd%0d dmem_resp", c), 32'(dmem_resp), 32'(m_busy && m_who && mem_resp));
      chk($sformatf("rnd%0d imem_rdata", c), imem_rdata,
          (m_busy && !m_who && mem_resp) ? mem_rdata : 32'h0);
      chk($sformatf("rnd%0d dmem_rdata", c), dmem_rdata,
          (m_busy && m_who && mem_resp) ? mem_rdata : 32'h0);
      if (m_busy) begin
        chk($sformatf("rnd%0d mem_address", c), mem_address, m_addr);
        if (m_wr) begin
          chk($sformatf("rnd%0d mem_wmask", c), 32'(mem_wmask), 32'(m_wmask));
          chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, m_wdata);
        end
        if (mem_resp) m_busy = 1'b0;
      end else begin
        any_d = dmem_read || dmem_write;
        if (imem_read || any_d) begin
          m_who = (imem_read && any_d) ? !m_last : any_d;
          if (m_who) begin
            m_addr = dmem_address; m_wr = dmem_write; m_rd = dmem_read && !dmem_write;
            m_wmask = dmem_wmask; m_wdata = dmem_wdata;
          end else begin
            m_addr = imem_address; m_rd = 1'b1; m_wr = 1'b0;
          end
          m_last = m_who;
          m_busy = 1'b1;
        end
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
